// File: rtl/riscv_div_issue.sv
// riscv_div_issue: issue/writeback sequencer wrapped around riscv_divider.
// Accepts one M-extension divide-class op (DIV/DIVU/REM/REMU) per handshake and
// launches it into the divider. It tracks rd/pc and captures the divider's
// one-cycle result pulse. That result is held on a valid/ready writeback port
// until accepted.
// Adds busy/stall, flush and a watchdog that the divider itself lacks.
//
// Optional feature macro: RISCV_DIV_BYPASS_EN
//   defined   - divide-by-zero ops skip the divider and write back directly.
//   undefined - divide-by-zero goes through the divider like any other op.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset (shared with divider)
//   in_valid/in_ready          issue handshake; in_ready = idle & !flush
//   in_code/in_pc/in_rd        instruction word, PC, destination register
//   in_a/in_b                  rs1/rs2 operand values
//   flush                      pipeline kill for the in-flight op
//   div_op_valid               one-cycle launch pulse to the divider
//   div_op_code/a/b            latched operands, held until the next accept
//   div_res_valid/div_res_out  divider result pulse and value
//   wb_valid/wb_ready          writeback handshake
//   wb_rd/wb_pc/wb_value       writeback payload
//   busy                       sequencer not idle
//   err                        one-cycle pulse: illegal op consumed or watchdog expiry
module riscv_div_issue #(
    parameter  int unsigned TIMEOUT_CYCLES = 63,
    localparam int unsigned XLEN           = 32,
    localparam int unsigned RW             = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_code,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RW-1:0]   in_rd,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            div_op_valid,
    output logic [XLEN-1:0] div_op_code,
    output logic [XLEN-1:0] div_op_a,
    output logic [XLEN-1:0] div_op_b,
    input  logic            div_res_valid,
    input  logic [XLEN-1:0] div_res_out,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_pc,
    output logic [XLEN-1:0] wb_value,
    output logic            busy,
    output logic            err
);

    localparam int unsigned CW         = 6;
    localparam logic [6:0]  OPC_OP     = 7'h33;
    localparam logic [6:0]  F7_MULDIV  = 7'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_WB,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wdog_q, wdog_d;
    logic            idle_q;
    logic            err_d;
    logic            lat_op;
    logic            lat_res;
`ifdef RISCV_DIV_BYPASS_EN
    logic            lat_byp;
`endif

    logic accept_c;
    logic divop_c;
    logic wdog_hit_c;

    // Idle flag is a register so in_ready is low while reset is held.
    assign in_ready   = idle_q & ~flush;
    assign accept_c   = in_valid & in_ready;
    assign divop_c    = (in_code[6:0] == OPC_OP) & (in_code[31:25] == F7_MULDIV) & in_code[14];
    assign wdog_hit_c = (wdog_q == CW'(TIMEOUT_CYCLES));

    // Next-state and latch-enable decode.
    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        err_d   = 1'b0;
        lat_op  = 1'b0;
        lat_res = 1'b0;
`ifdef RISCV_DIV_BYPASS_EN
        lat_byp = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                wdog_d = '0;
                if (accept_c) begin
                    if (divop_c) begin
                        lat_op = 1'b1;
`ifdef RISCV_DIV_BYPASS_EN
                        if (in_b == '0) begin
                            lat_byp = 1'b1;
                            state_d = (in_rd != '0) ? S_WB : S_IDLE;
                        end else begin
                            state_d = S_LAUNCH;
                        end
`else
                        state_d = S_LAUNCH;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // Divider samples the op this cycle, so a flush must still drain it.
            S_LAUNCH: state_d = flush ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                wdog_d = wdog_q + CW'(1);
                if (flush && div_res_valid) begin
                    state_d = S_IDLE;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end else if (div_res_valid) begin
                    lat_res = 1'b1;
                    state_d = (wb_rd != '0) ? S_WB : S_IDLE;
                end else if (wdog_hit_c) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                if (flush || wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                wdog_d = wdog_q + CW'(1);
                if (div_res_valid) begin
                    state_d = S_IDLE;
                end else if (wdog_hit_c) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wdog_q       <= '0;
            idle_q       <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            div_op_valid <= 1'b0;
            wb_valid     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wdog_q       <= wdog_d;
            idle_q       <= (state_d == S_IDLE);
            busy         <= (state_d != S_IDLE);
            err          <= err_d;
            div_op_valid <= (state_d == S_LAUNCH);
            wb_valid     <= (state_d == S_WB);
        end
    end

    // Operand and writeback payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_op_code <= '0;
            div_op_a    <= '0;
            div_op_b    <= '0;
            wb_rd       <= '0;
            wb_pc       <= '0;
            wb_value    <= '0;
        end else begin
            if (lat_op) begin
                div_op_code <= in_code;
                div_op_a    <= in_a;
                div_op_b    <= in_b;
                wb_rd       <= in_rd;
                wb_pc       <= in_pc;
            end
            if (lat_res) begin
                wb_value <= div_res_out;
            end
`ifdef RISCV_DIV_BYPASS_EN
            // funct3[1] set selects REM/REMU, which return the dividend on /0.
            else if (lat_byp) begin
                wb_value <= in_code[13] ? in_a : '1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_riscv_div_issue.sv
// Testbench for riscv_div_issue: emulates riscv_divider behaviourally and
// checks the sequencer's handshakes, flush, watchdog and writeback payloads.
module tb_riscv_div_issue;

    localparam int CLK_HALF = 5;
    localparam int DIV_LAT  = 33;
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_code = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        flush = 1'b0;
    logic        div_op_valid;
    logic [31:0] div_op_code;
    logic [31:0] div_op_a;
    logic [31:0] div_op_b;
    logic        div_res_valid;
    logic [31:0] div_res_out;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_pc;
    logic [31:0] wb_value;
    logic        busy;
    logic        err;

    int tests = 0;
    int fails = 0;

    int  launches = 0;
    bit  drop_res = 1'b0;

    riscv_div_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_pc(in_pc), .in_rd(in_rd), .in_a(in_a), .in_b(in_b),
        .flush(flush),
        .div_op_valid(div_op_valid), .div_op_code(div_op_code),
        .div_op_a(div_op_a), .div_op_b(div_op_b),
        .div_res_valid(div_res_valid), .div_res_out(div_res_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_pc(wb_pc), .wb_value(wb_value),
        .busy(busy), .err(err)
    );

    always #CLK_HALF clk = ~clk;

    function automatic logic [31:0] enc(input logic [2:0] f3, input logic [6:0] f7);
        return {f7, 5'd2, 5'd1, f3, 5'd5, 7'h33};
    endfunction

    // RISC-V M-extension divide semantics, including /0 and signed overflow.
    function automatic logic [31:0] ref_div(input logic [31:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (code[13:12])
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Behavioural divider: samples a launch, answers DIV_LAT cycles later.
    initial begin
        bit          pend;
        int          cnt;
        logic [31:0] res;
        bit          seen;
        logic [31:0] sc, sa, sb;
        pend = 0; cnt = 0; res = '0;
        div_res_valid = 1'b0;
        div_res_out   = '0;
        forever begin
            @(negedge clk);
            seen = (div_op_valid === 1'b1);
            sc = div_op_code; sa = div_op_a; sb = div_op_b;
            @(posedge clk);
            #1;
            div_res_valid = 1'b0;
            if (!rst_n) begin
                pend = 0;
                continue;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend = 0;
                    if (!drop_res) begin
                        div_res_valid = 1'b1;
                        div_res_out   = res;
                    end
                end
            end
            if (seen) begin
                tests++;
                if (pend) begin
                    fails++;
                    $display("FAIL one_outstanding: launch while busy, got pend=%0d required 0", pend);
                end
                pend = 1;
                cnt  = DIV_LAT;
                res  = ref_div(sc, sa, sb);
                launches++;
            end
        end
    end

    task automatic issue(input logic [31:0] code, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b,
                         output bit ok, output int waited);
        in_code = code; in_pc = pc; in_rd = rd; in_a = a; in_b = b;
        in_valid = 1'b1;
        ok = 0; waited = 0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1; waited = i;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_wb(input int budget, output bit got, output int cyc, output bit res_prev,
                           output int rdy_hi, output int op_hi);
        bit prev;
        got = 0; cyc = 0; res_prev = 0; rdy_hi = 0; op_hi = 0;
        prev = div_res_valid;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                got = 1; cyc = i; res_prev = prev;
                break;
            end
            if (in_ready === 1'b1) rdy_hi++;
            if (div_op_valid === 1'b1) op_hi++;
            prev = div_res_valid;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok, output bit saw_wb);
        ok = 0; saw_wb = 0;
        for (int i = 0; i < budget; i++) begin
            if (wb_valid === 1'b1) saw_wb = 1;
            if (busy === 1'b0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({in_ready, div_op_valid, wb_valid, busy, err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 00000", {in_ready, div_op_valid, wb_valid, busy, err});
        end
        tests++;
        if ({wb_rd, wb_pc, wb_value, div_op_code, div_op_a, div_op_b} !== '0) begin
            fails++;
            $display("FAIL reset_data: got rd=%h pc=%h val=%h code=%h required all zero", wb_rd, wb_pc, wb_value, div_op_code);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: got in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_divu_basic();
        bit ok, got, rp; int w, cyc, rh, oh, l0;
        wb_ready = 1'b1;
        l0 = launches;
        issue(enc(F3_DIVU, 7'h01), 32'h0000_1000, 5'd5, 32'd100, 32'd7, ok, w);
        tests++;
        if (!ok || div_op_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL divu_launch: got ok=%0d op_valid=%b busy=%b in_ready=%b required 1 1 1 0", ok, div_op_valid, busy, in_ready);
        end
        tests++;
        if ({div_op_code, div_op_a, div_op_b} !== {enc(F3_DIVU, 7'h01), 32'd100, 32'd7}) begin
            fails++;
            $display("FAIL divu_operands: got %h %h %h required %h 64 7", div_op_code, div_op_a, div_op_b, enc(F3_DIVU, 7'h01));
        end
        wait_wb(100, got, cyc, rp, rh, oh);
        tests++;
        if (!got || !rp) begin
            fails++;
            $display("FAIL divu_wb_timing: got wb=%0d res_prev_cycle=%0d required 1 1", got, rp);
        end
        tests++;
        if (wb_rd !== 5'd5 || wb_value !== 32'd14 || wb_pc !== 32'h0000_1000) begin
            fails++;
            $display("FAIL divu_payload: got rd=%0d val=%0d pc=%h required 5 14 00001000", wb_rd, wb_value, wb_pc);
        end
        tests++;
        if (rh != 0 || oh != 0 || launches - l0 != 1) begin
            fails++;
            $display("FAIL divu_single_launch: got ready_hi=%0d extra_pulses=%0d launches=%0d required 0 0 1", rh, oh, launches - l0);
        end
        @(negedge clk);
        tests++;
        if (wb_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL divu_return_idle: got wb=%b busy=%b in_ready=%b required 0 0 1", wb_valid, busy, in_ready);
        end
    endtask

    task automatic test_rem_signed();
        bit ok, got, rp; int w, cyc, rh, oh;
        wb_ready = 1'b1;
        issue(enc(F3_REM, 7'h01), 32'h0000_2468, 5'd3, 32'hFFFF_FFF9, 32'd2, ok, w);
        wait_wb(100, got, cyc, rp, rh, oh);
        tests++;
        if (!got || wb_value !== 32'hFFFF_FFFF || wb_pc !== 32'h0000_2468 || wb_rd !== 5'd3) begin
            fails++;
            $display("FAIL rem_signed: got wb=%0d val=%h pc=%h rd=%0d required 1 ffffffff 00002468 3", got, wb_value, wb_pc, wb_rd);
        end
        @(negedge clk);
    endtask

    task automatic test_rd_zero();
        bit ok, idle, saw; int w, l0;
        wb_ready = 1'b1;
        l0 = launches;
        issue(enc(F3_DIV, 7'h01), 32'h0000_3000, 5'd0, -32'sd20, 32'd3, ok, w);
        tests++;
        if (busy !== 1'b1 || div_op_valid !== 1'b1) begin
            fails++;
            $display("FAIL rd0_busy: got busy=%b op_valid=%b required 1 1", busy, div_op_valid);
        end
        wait_idle(100, idle, saw);
        tests++;
        if (!idle || saw || launches - l0 != 1) begin
            fails++;
            $display("FAIL rd0_no_wb: got idle=%0d saw_wb=%0d launches=%0d required 1 0 1", idle, saw, launches - l0);
        end
    endtask

    task automatic test_backpressure();
        bit ok, got, rp; int w, cyc, rh, oh;
        wb_ready = 1'b0;
        issue(enc(F3_DIVU, 7'h01), 32'h0000_4000, 5'd9, 32'd50, 32'd5, ok, w);
        wait_wb(100, got, cyc, rp, rh, oh);
        tests++;
        if (!got || wb_rd !== 5'd9 || wb_value !== 32'd10) begin
            fails++;
            $display("FAIL bp_first: got wb=%0d rd=%0d val=%0d required 1 9 10", got, wb_rd, wb_value);
        end
        for (int s = 2; s <= 6; s++) begin
            @(negedge clk);
            tests++;
            if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || wb_value !== 32'd10 || wb_pc !== 32'h0000_4000) begin
                fails++;
                $display("FAIL bp_hold_%0d: got wb=%b rd=%0d val=%0d pc=%h required 1 9 10 00004000", s, wb_valid, wb_rd, wb_value, wb_pc);
            end
        end
        wb_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got wb=%b in_ready=%b required 0 1", wb_valid, in_ready);
        end
        issue(enc(F3_DIVU, 7'h01), 32'h0000_4004, 5'd1, 32'd77, 32'd7, ok, w);
        wait_wb(100, got, cyc, rp, rh, oh);
        tests++;
        if (!ok || w != 0 || !got || wb_value !== 32'd11) begin
            fails++;
            $display("FAIL bp_next_op: got ok=%0d waited=%0d wb=%0d val=%0d required 1 0 1 11", ok, w, got, wb_value);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        bit ok, got, rp, idle, saw, early, seen; int w, cyc, rh, oh, l0;
        wb_ready = 1'b1;
        // Flush while waiting on the divider.
        issue(enc(F3_DIVU, 7'h01), 32'h0000_5000, 5'd6, 32'd1000, 32'd10, ok, w);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        early = 0; saw = 0; seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wb_valid === 1'b1) saw = 1;
            if (busy !== 1'b1) early = 1;
            if (div_res_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        @(negedge clk);
        tests++;
        if (!seen || early || saw || busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_wait_drain: got res=%0d early_idle=%0d saw_wb=%0d busy=%b required 1 0 0 0", seen, early, saw, busy);
        end
        issue(enc(F3_DIVU, 7'h01), 32'h0000_5004, 5'd7, 32'd81, 32'd9, ok, w);
        wait_wb(100, got, cyc, rp, rh, oh);
        tests++;
        if (!got || wb_value !== 32'd9 || wb_rd !== 5'd7) begin
            fails++;
            $display("FAIL flush_next_op: got wb=%0d val=%0d rd=%0d required 1 9 7", got, wb_value, wb_rd);
        end
        @(negedge clk);
        // Flush during the launch cycle: divider still runs, result discarded.
        l0 = launches;
        issue(enc(F3_DIV, 7'h01), 32'h0000_5008, 5'd8, 32'd100, 32'd3, ok, w);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_idle(100, idle, saw);
        tests++;
        if (!idle || saw || launches - l0 != 1) begin
            fails++;
            $display("FAIL flush_launch: got idle=%0d saw_wb=%0d launches=%0d required 1 0 1", idle, saw, launches - l0);
        end
        issue(enc(F3_DIV, 7'h01), 32'h0000_500C, 5'd8, -32'sd100, 32'd7, ok, w);
        wait_wb(100, got, cyc, rp, rh, oh);
        tests++;
        if (!got || wb_value !== 32'hFFFF_FFF2) begin
            fails++;
            $display("FAIL flush_launch_next: got wb=%0d val=%h required 1 fffffff2", got, wb_value);
        end
        // Flush while holding a writeback.
        wb_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests++;
        if (wb_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_wb: got wb=%b busy=%b required 0 0", wb_valid, busy);
        end
    endtask

    task automatic test_illegal();
        bit ok; int w, l0;
        l0 = launches;
        flush = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_blocks_ready: got in_ready=%b required 0", in_ready);
        end
        flush = 1'b0;
        issue(enc(3'b000, 7'h01), 32'h0000_6000, 5'd4, 32'd6, 32'd3, ok, w);
        tests++;
        if (!ok || err !== 1'b1 || busy !== 1'b0 || div_op_valid !== 1'b0) begin
            fails++;
            $display("FAIL illegal_err: got ok=%0d err=%b busy=%b op_valid=%b required 1 1 0 0", ok, err, busy, div_op_valid);
        end
        @(negedge clk);
        tests++;
        if (err !== 1'b0 || wb_valid !== 1'b0 || launches != l0) begin
            fails++;
            $display("FAIL illegal_pulse: got err=%b wb=%b launches=%0d required 0 0 0", err, wb_valid, launches - l0);
        end
    endtask

    task automatic test_timeout();
        bit ok, gerr, saw; int w, cyc;
        wb_ready = 1'b1;
        drop_res = 1'b1;
        issue(enc(F3_DIVU, 7'h01), 32'h0000_7000, 5'd2, 32'd5, 32'd1, ok, w);
        gerr = 0; saw = 0; cyc = 0;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (wb_valid === 1'b1) saw = 1;
            if (err === 1'b1) begin
                gerr = 1; cyc = i;
                break;
            end
        end
        tests++;
        if (!gerr || saw || cyc < 40 || cyc > 70 || busy !== 1'b0) begin
            fails++;
            $display("FAIL watchdog: got err=%0d at cycle %0d saw_wb=%0d busy=%b required err in 40..70, no wb, idle", gerr, cyc, saw, busy);
        end
        drop_res = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div_by_zero();
        bit ok, got, rp; int w, cyc, rh, oh, l0;
        l0 = launches;
`ifdef RISCV_DIV_BYPASS_EN
        wb_ready = 1'b0;
        issue(enc(F3_DIVU, 7'h01), 32'h0000_8000, 5'd4, 32'd9, 32'd0, ok, w);
        tests++;
        if (wb_valid !== 1'b1 || div_op_valid !== 1'b0 || wb_value !== 32'hFFFF_FFFF || wb_rd !== 5'd4) begin
            fails++;
            $display("FAIL bypass_divu: got wb=%b op_valid=%b val=%h rd=%0d required 1 0 ffffffff 4", wb_valid, div_op_valid, wb_value, wb_rd);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        issue(enc(F3_REMU, 7'h01), 32'h0000_8004, 5'd4, 32'd9, 32'd0, ok, w);
        tests++;
        if (wb_valid !== 1'b1 || wb_value !== 32'd9) begin
            fails++;
            $display("FAIL bypass_remu: got wb=%b val=%h required 1 00000009", wb_valid, wb_value);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        issue(enc(F3_DIV, 7'h01), 32'h0000_8008, 5'd0, 32'd9, 32'd0, ok, w);
        repeat (3) @(negedge clk);
        tests++;
        if (wb_valid !== 1'b0 || busy !== 1'b0 || launches != l0) begin
            fails++;
            $display("FAIL bypass_rd0: got wb=%b busy=%b launches=%0d required 0 0 0", wb_valid, busy, launches - l0);
        end
`else
        wb_ready = 1'b1;
        issue(enc(F3_DIVU, 7'h01), 32'h0000_8000, 5'd4, 32'd9, 32'd0, ok, w);
        tests++;
        if (div_op_valid !== 1'b1) begin
            fails++;
            $display("FAIL divzero_launch: got op_valid=%b required 1", div_op_valid);
        end
        wait_wb(100, got, cyc, rp, rh, oh);
        tests++;
        if (!got || wb_value !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL divzero_divu: got wb=%0d val=%h required 1 ffffffff", got, wb_value);
        end
        @(negedge clk);
        issue(enc(F3_REMU, 7'h01), 32'h0000_8004, 5'd4, 32'd9, 32'd0, ok, w);
        wait_wb(100, got, cyc, rp, rh, oh);
        tests++;
        if (!got || wb_value !== 32'd9 || launches - l0 != 2) begin
            fails++;
            $display("FAIL divzero_remu: got wb=%0d val=%h launches=%0d required 1 00000009 2", got, wb_value, launches - l0);
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_midop();
        bit ok, saw; int w;
        wb_ready = 1'b1;
        issue(enc(F3_DIVU, 7'h01), 32'h0000_9000, 5'd10, 32'd90, 32'd9, ok, w);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || div_op_code !== 32'h0) begin
            fails++;
            $display("FAIL reset_midop: got busy=%b wb=%b code=%h required 0 0 00000000", busy, wb_valid, div_op_code);
        end
        rst_n = 1'b1;
        saw = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wb_valid === 1'b1 || busy === 1'b1) saw = 1;
        end
        tests++;
        if (saw) begin
            fails++;
            $display("FAIL reset_abandon: got activity=%0d required 0", saw);
        end
    endtask

    task automatic test_random();
        bit ok, got, rp, idle, saw, byp; int w, cyc, rh, oh, l0, d, sel;
        logic [2:0] f3; logic [31:0] a, b, exp_v, pc; logic [4:0] rd;
        for (int n = 0; n < 12; n++) begin
            f3  = 3'(4 + $urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 0) b = 32'h0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 255));
            rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pc  = $urandom & 32'hFFFF_FFFC;
            d   = $urandom_range(0, 3);
            exp_v = ref_div(enc(f3, 7'h01), a, b);
`ifdef RISCV_DIV_BYPASS_EN
            byp = (b == 0);
`else
            byp = 0;
`endif
            l0 = launches;
            wb_ready = 1'b0;
            issue(enc(f3, 7'h01), pc, rd, a, b, ok, w);
            if (rd != 0) begin
                if (wb_valid === 1'b1) got = 1;
                else wait_wb(100, got, cyc, rp, rh, oh);
                tests++;
                if (!got || wb_value !== exp_v || wb_rd !== rd || wb_pc !== pc) begin
                    fails++;
                    $display("FAIL rand_%0d: f3=%b a=%h b=%h got wb=%0d val=%h rd=%0d pc=%h required 1 %h %0d %h",
                             n, f3, a, b, got, wb_value, wb_rd, wb_pc, exp_v, rd, pc);
                end
                repeat (d) @(negedge clk);
                wb_ready = 1'b1;
                @(negedge clk);
                wb_ready = 1'b0;
            end else begin
                wait_idle(100, idle, saw);
                tests++;
                if (!idle || saw) begin
                    fails++;
                    $display("FAIL rand_rd0_%0d: got idle=%0d saw_wb=%0d required 1 0", n, idle, saw);
                end
            end
            repeat (2) @(negedge clk);
            tests++;
            if (launches - l0 != (byp ? 0 : 1) || busy !== 1'b0) begin
                fails++;
                $display("FAIL rand_launch_%0d: got launches=%0d busy=%b required %0d 0", n, launches - l0, busy, byp ? 0 : 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_rem_signed();
        test_rd_zero();
        test_backpressure();
        test_flush();
        test_illegal();
        test_timeout();
        test_div_by_zero();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
